// File: rtl/ruppel_sdg_chk_if.sv
// Bit-stream link between a PRSG receiver front end and the sequence checker.
interface ruppel_sdg_chk_if;
    logic        din;
    logic        din_vld;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic        sync_loss;
    logic [15:0] err_cnt;

    modport master (
        output din, din_vld, clr_cnt,
        input  locked, err_pulse, sync_loss, err_cnt
    );

    modport slave (
        input  din, din_vld, clr_cnt,
        output locked, err_pulse, sync_loss, err_cnt
    );
endinterface

// File: rtl/ruppel_sdg_chk.sv
// Self-synchronising checker for the Rueppel self-decimated PRSG stream (x^32+x^22+x^2+x+1).
// Loads a local LFSR copy from received bits, verifies, then flywheels while counting errors.
module ruppel_sdg_chk #(
    parameter int unsigned LOCK_CNT = 64,
    parameter int unsigned LOSS_ERR = 8,
    parameter int unsigned WINDOW   = 128
) (
    input  logic             clk,
    input  logic             rst,
    ruppel_sdg_chk_if.slave  bus
);

    localparam int unsigned R_W    = 32;
    localparam int unsigned FILL_W = 6;
    localparam int unsigned GOOD_W = 8;
    localparam int unsigned WCNT_W = 16;
    localparam int unsigned WERR_W = 8;
    localparam int unsigned ECNT_W = 16;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [R_W-1:0]      r_q, r_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]   win_err_q, win_err_d;
    logic [WERR_W-1:0]   win_err_nxt;
    logic [ECNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic                sync_loss_q, sync_loss_d;
    logic                pred_c;
    logic                mism_c;
    logic [R_W-1:0]      r_din_c;

    assign pred_c  = r_q[31] ^ r_q[21] ^ r_q[1] ^ r_q[0];
    assign mism_c  = bus.din ^ pred_c;
    assign r_din_c = {r_q[R_W-2:0], bus.din};

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            r_q         <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sync_loss_q <= sync_loss_d;
        end
    end

    // Next-state and output decode; only valid bits advance anything
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        good_d      = good_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        win_err_nxt = win_err_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        sync_loss_d = 1'b0;

        if (bus.din_vld) begin
            case (state_q)
                ST_HUNT: begin
                    r_d    = r_din_c;
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(31)) begin
                        fill_d = '0;
                        if (r_din_c != '0) begin
                            state_d = ST_VERIFY;
                            good_d  = '0;
                        end
                    end
                end
                ST_VERIFY: begin
                    r_d = r_din_c;
                    if (!mism_c) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_q + GOOD_W'(1) == GOOD_W'(LOCK_CNT)) begin
                            state_d   = ST_LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        fill_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the local prediction, not the line bit, feeds the register
                    r_d         = {r_q[R_W-2:0], pred_c};
                    win_err_nxt = win_err_q + WERR_W'(mism_c);
                    win_err_d   = win_err_nxt;
                    win_cnt_d   = win_cnt_q + WCNT_W'(1);
                    if (mism_c) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ECNT_W'(1);
                        end
                    end
                    if (win_cnt_q + WCNT_W'(1) == WCNT_W'(WINDOW)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                    if (win_err_nxt == WERR_W'(LOSS_ERR)) begin
                        state_d     = ST_HUNT;
                        fill_d      = '0;
                        sync_loss_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        if (bus.clr_cnt) begin
            err_cnt_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.sync_loss = sync_loss_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ruppel_sdg_chk.sv
// Randomized and directed bench for ruppel_sdg_chk against a bit-history reference model.
module tb_ruppel_sdg_chk;

    localparam int unsigned LOCK_CNT = 64;
    localparam int unsigned LOSS_ERR = 8;
    localparam int unsigned WINDOW   = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ruppel_sdg_chk_if bus ();

    ruppel_sdg_chk #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_ERR (LOSS_ERR),
        .WINDOW   (WINDOW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int pulses_seen = 0;
    int loss_seen   = 0;

    // reference model: last 32 received/flywheel bits, newest at the back
    bit hist[$];
    int ms;            // 0 hunt, 1 verify, 2 locked
    int m_fill, m_good, m_wcnt, m_werr, m_ecnt;
    bit m_locked, m_pulse, m_loss;

    // reference generator
    logic [31:0] g;
    int          gidx;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errs++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 32; i++) hist.push_back(1'b0);
        ms = 0; m_fill = 0; m_good = 0; m_wcnt = 0; m_werr = 0; m_ecnt = 0;
        m_locked = 0; m_pulse = 0; m_loss = 0;
    endtask

    task automatic push_hist(input bit b);
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic model_step(input bit vld, input bit d, input bit clr);
        bit p;
        bit nz;
        bit lost;
        m_pulse = 0;
        m_loss  = 0;
        if (vld) begin
            // ages 31, 21, 1, 0 measured back from the newest bit
            p = hist[0] ^ hist[10] ^ hist[30] ^ hist[31];
            if (ms == 0) begin
                push_hist(d);
                m_fill++;
                if (m_fill == 32) begin
                    m_fill = 0;
                    nz = 0;
                    foreach (hist[i]) nz |= hist[i];
                    if (nz) begin ms = 1; m_good = 0; end
                end
            end else if (ms == 1) begin
                push_hist(d);
                if (d == p) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin ms = 2; m_wcnt = 0; m_werr = 0; end
                end else begin
                    ms = 0; m_fill = 0;
                end
            end else begin
                push_hist(p);
                m_wcnt++;
                if (d != p) begin
                    m_pulse = 1;
                    if (m_ecnt < 65535) m_ecnt++;
                    m_werr++;
                end
                lost = (m_werr == LOSS_ERR);
                if (m_wcnt == WINDOW) begin m_wcnt = 0; m_werr = 0; end
                if (lost) begin ms = 0; m_fill = 0; m_loss = 1; end
            end
        end
        if (clr) m_ecnt = 0;
        m_locked = (ms == 2);
    endtask

    task automatic next_ref(output bit b);
        logic [31:0] seed;
        seed = 32'h0000_0001;
        if (gidx < 32) b = seed[31 - gidx];
        else           b = g[31] ^ g[21] ^ g[1] ^ g[0];
        g = {g[30:0], b};
        gidx++;
    endtask

    task automatic do_cycle(input bit vld, input bit d, input bit clr);
        bus.din_vld = vld;
        bus.din     = d;
        bus.clr_cnt = clr;
        @(posedge clk);
        model_step(vld, d, clr);
        #1;
        check("locked",    int'(bus.locked),    int'(m_locked));
        check("err_pulse", int'(bus.err_pulse), int'(m_pulse));
        check("sync_loss", int'(bus.sync_loss), int'(m_loss));
        check("err_cnt",   int'(bus.err_cnt),   m_ecnt);
        if (bus.err_pulse) pulses_seen++;
        if (bus.sync_loss) loss_seen++;
        bus.din_vld = 1'b0;
        bus.clr_cnt = 1'b0;
    endtask

    task automatic send(input bit d, input int gap, input bit clr);
        do_cycle(1'b1, d, clr);
        repeat (gap) do_cycle(1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic send_ref(input bit flip, input int gap);
        bit b;
        next_ref(b);
        send(b ^ flip, gap, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.din = 1'b0; bus.din_vld = 1'b0; bus.clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked",    int'(bus.locked),    0);
        check("rst_err_pulse", int'(bus.err_pulse), 0);
        check("rst_sync_loss", int'(bus.sync_loss), 0);
        check("rst_err_cnt",   int'(bus.err_cnt),   0);
        rst = 1'b0;
        model_reset();
        g = '0;
        gidx = 0;
    endtask

    // gapmode 0: back-to-back, 1: self-decimation spacing
    task automatic lock_wait(input int gapmode, output int n);
        bit b;
        n = 0;
        while (!bus.locked && n < 400) begin
            next_ref(b);
            send(b, (gapmode == 0) ? 0 : (b ? 2 : 1), 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        int p0;
        int loss_at;
        bit b;
        bit seen;

        // lock-up, continuous valid
        do_reset();
        lock_wait(0, n);
        check("lock_bits_cont", n, 96);
        repeat (1000 - n) send_ref(1'b0, 0);
        check("err_cnt_1000", int'(bus.err_cnt), 0);

        // lock-up with self-decimation gaps
        do_reset();
        lock_wait(1, n);
        check("lock_bits_gap", n, 96);
        check("gap_pulses", pulses_seen, 0);

        // single error in lock
        p0 = pulses_seen;
        repeat (20) send_ref(1'b0, 0);
        send_ref(1'b1, 0);
        repeat (200) send_ref(1'b0, $urandom_range(0, 2));
        check("single_pulses", pulses_seen - p0, 1);
        check("single_err_cnt", int'(bus.err_cnt), 1);
        check("single_locked", int'(bus.locked), 1);

        // loss of sync: 8 errors in the first window after lock
        do_reset();
        lock_wait(0, n);
        loss_at = -1;
        for (int k = 0; k <= 75; k++) begin
            send_ref(k % 10 == 5, 0);
            if (bus.sync_loss) loss_at = k;
        end
        check("loss_at", loss_at, 75);
        check("loss_count", loss_seen, 1);
        check("loss_locked", int'(bus.locked), 0);
        check("loss_err_cnt", int'(bus.err_cnt), 8);
        lock_wait(0, n);
        check("relock_bits", n, 96);

        // 7 errors in one window and 7 in the next keep lock
        do_cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 256; k++) begin
            send_ref((k >= 10 && k <= 70 && k % 10 == 0) ||
                     (k >= 140 && k <= 200 && k % 10 == 0), 0);
        end
        check("7x2_locked", int'(bus.locked), 1);
        check("7x2_err_cnt", int'(bus.err_cnt), 14);
        check("7x2_loss", loss_seen, 1);

        // clear in the same cycle as a counted error
        next_ref(b);
        send(~b, 0, 1'b1);
        check("clr_pulse", int'(bus.err_pulse), 1);
        check("clr_err_cnt", int'(bus.err_cnt), 0);

        // asynchronous reset in LOCKED with a nonzero count
        send_ref(1'b1, 0);
        check("pre_rst_cnt", int'(bus.err_cnt), 1);
        #3 rst = 1'b1;
        #1;
        check("async_locked",    int'(bus.locked),    0);
        check("async_err_cnt",   int'(bus.err_cnt),   0);
        check("async_err_pulse", int'(bus.err_pulse), 0);
        check("async_sync_loss", int'(bus.sync_loss), 0);

        // degenerate all-zero input never locks
        do_reset();
        seen = 0;
        repeat (500) begin
            send(1'b0, 0, 1'b0);
            seen |= bus.locked;
        end
        check("zeros_locked", int'(seen), 0);

        // VERIFY failure restarts the 32+64 count from the flip
        do_reset();
        p0 = pulses_seen;
        repeat (42) send_ref(1'b0, 0);
        send_ref(1'b1, 0);
        check("flip_locked", int'(bus.locked), 0);
        lock_wait(0, n);
        check("flip_relock_bits", n, 96);
        check("flip_pulses", pulses_seen - p0, 0);
        check("flip_err_cnt", int'(bus.err_cnt), 0);

        // randomized traffic against the model
        do_reset();
        repeat (5000) begin
            if ($urandom_range(0, 9) < 6) begin
                next_ref(b);
                b ^= (ms == 2) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 399) == 0);
                do_cycle(1'b1, b, $urandom_range(0, 499) == 0);
            end else begin
                do_cycle(1'b0, 1'($urandom), $urandom_range(0, 499) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ruppel_sdg_chk.md
# ruppel_sdg_chk

Self-synchronising sequence checker for the Rueppel self-decimated generator's output stream. It sits at the receiving end of the PRSG link. Each bit arrives with a valid strobe, at whatever decimated rate the generator produced it. The block loads its own copy of the 32-bit LFSR state from the received bits, predicts each following bit, declares lock after a run of correct predictions, and counts bit errors while locked. Since self-decimation changes only the spacing of the bits and never their values, the block checks content only.

## Interface
- LOCK_CNT, 64: consecutive correct predictions in VERIFY needed to enter LOCKED (range 1..255).
- LOSS_ERR, 8: mismatches within one WINDOW in LOCKED that force loss of sync (range 1..255).
- WINDOW, 128: length of the error-accounting window, in valid bits (range 2..65535).
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  received PRSG bit.
- din_vld  input  1  din is sampled only when high; gaps of any length are legal.
- clr_cnt  input  1  synchronous clear of err_cnt.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse for each mismatching bit while LOCKED.
- sync_loss  output  1  one-cycle pulse on the LOCKED->HUNT transition.
- err_cnt  output  16  saturating total of mismatches while LOCKED.

## Operation
- LFSR model: x^32+x^22+x^2+x+1.
- R[31:0] holds the received history, with R[0] the newest bit. On each step R <= {R[30:0], b}.
- Prediction: p = R[31]^R[21]^R[1]^R[0].
- States: HUNT, VERIFY, LOCKED. Reset state is HUNT.
- HUNT:
  - Each valid bit shifts din into R and increments fill (6 bits).
  - When the 32nd bit arrives (fill reaches 32): if the new R != 0, go to VERIFY with good = 0; otherwise stay in HUNT with fill = 0.
- VERIFY:
  - Each valid bit compares din with p, and din is shifted into R.
  - Match: good++. When good reaches LOCK_CNT, go to LOCKED; win_cnt and win_err are cleared.
  - Mismatch: go to HUNT with fill = 0. R is kept but must be refilled.
- LOCKED (flywheel):
  - Each valid bit shifts p, not din, into R, so line errors do not corrupt the state.
  - Mismatch (din != p): err_pulse fires, err_cnt increments (saturating at 16'hFFFF), and win_err increments.
  - win_cnt counts valid bits. When win_cnt reaches WINDOW, both win_cnt and win_err clear on that bit, after that bit's error has been evaluated.
  - If win_err reaches LOSS_ERR: go to HUNT, fill = 0, and pulse sync_loss. The mismatch that causes the loss still pulses err_pulse and counts in err_cnt.
- No other transitions occur. The state is held on cycles with din_vld = 0.
- clr_cnt sets err_cnt to 0. If a counted mismatch lands in the same cycle, clr_cnt wins and err_cnt becomes 0.
- err_cnt survives loss of lock; only rst or clr_cnt clears it.

## Timing
- All outputs are registered. A bit sampled at edge N is reflected in the outputs after edge N, with no further latency.
- Reset values: locked = 0, err_pulse = 0, sync_loss = 0, err_cnt = 0, R = 0, fill = 0, good = 0, win_cnt = 0, win_err = 0, state = HUNT.
- rst asserted mid-operation returns all of the above to their reset values immediately, without waiting for a clock edge.
- Minimum bits to lock, with no gaps and no errors: 32 + LOCK_CNT valid bits. locked rises on the edge that samples bit 32+LOCK_CNT.
- err_pulse and sync_loss are high for exactly one cycle per event, even when din_vld is high on back-to-back cycles.
- locked falls on the same edge on which sync_loss rises.

## Test plan
- Lock-up: use a reference LFSR seeded 32'h0000_0001, with din_vld high every cycle. Required: locked rises on the edge sampling bit 96 (default parameters); err_cnt = 0 after 1000 bits.
- Decimated gaps: same stream, but din_vld follows the self-decimation pattern, 1-cycle gap when the previous bit = 0 and 2-cycle gap when it = 1. Required: locked rises after exactly 96 valid bits, with no errors.
- Single error in lock: invert one bit after lock. Required: exactly one err_pulse, err_cnt = 1, locked stays 1, and the following 200 bits show no further errors (flywheel holds).
- Loss of sync: after lock, invert 8 bits within one 128-bit window. Required: sync_loss pulses on the 8th error, locked = 0, err_cnt = 8, and relock occurs 96 bits later. Also invert 7 bits in one window and 7 in the next. Required: still locked, err_cnt = 14.
- Degenerate input and VERIFY failure: send 500 zero bits. Required: locked never asserts. Also flip one bit during VERIFY. Required: no err_pulse, err_cnt unchanged, and locked delayed until the 32+64 count restarts from the flip.
- Reset and clear: assert rst mid-LOCKED. Required: all outputs 0 immediately. Also assert clr_cnt in the same cycle as a counted error. Required: err_cnt = 0.
